// File: rtl/cpu_pkg.sv
// Shared datapath widths, ALU operation encoding and the control bundle
// that travels down the pipeline as a single field.
package cpu_pkg;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 5;
    localparam int ALU_W  = 4;
    localparam int PC_REG = 19;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        alu_op_e alu_ctrl;
    } ctrl_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stage_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: the load in EX writes a register that the decode
// instruction reads. The hard-zero register and the PC are never sources.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic              valid_d,
    input  logic              valid_e,
    input  logic              mem_read_e,
    input  logic [ADDR_W-1:0] a1_d,
    input  logic [ADDR_W-1:0] a2_d,
    input  logic [ADDR_W-1:0] a3_e,
    output logic              hazard
);

    assign hazard = valid_d && valid_e && mem_read_e
                 && (a3_e != '0)
                 && (a3_e != ADDR_W'(PC_REG))
                 && ((a3_e == a1_d) || (a3_e == a2_d));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall sequencing and branch flush.
// A hazard cycle plus LOAD_STALL-1 cycles in STALL give LOAD_STALL bubbles.
module id_ex_stage_reg
    import cpu_pkg::*;
#(
    parameter int LOAD_STALL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_d,
    input  logic [ADDR_W-1:0] a1_d,
    input  logic [ADDR_W-1:0] a2_d,
    input  logic [ADDR_W-1:0] a3_d,
    input  logic [DATA_W-1:0] rd1_d,
    input  logic [DATA_W-1:0] rd2_d,
    input  logic [DATA_W-1:0] imm_d,
    input  logic              reg_write_d,
    input  logic              mem_read_d,
    input  logic              mem_write_d,
    input  logic [ALU_W-1:0]  alu_ctrl_d,
    input  logic              flush_e,
    output logic              stall_d,
    output logic              valid_e,
    output logic [ADDR_W-1:0] a1_e,
    output logic [ADDR_W-1:0] a2_e,
    output logic [ADDR_W-1:0] a3_e,
    output logic [DATA_W-1:0] rd1_e,
    output logic [DATA_W-1:0] rd2_e,
    output logic [DATA_W-1:0] imm_e,
    output logic              reg_write_e,
    output logic              mem_read_e,
    output logic              mem_write_e,
    output logic [ALU_W-1:0]  alu_ctrl_e
);

    stage_state_e      state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_a1_q, ex_a1_d;
    logic [ADDR_W-1:0] ex_a2_q, ex_a2_d;
    logic [ADDR_W-1:0] ex_a3_q, ex_a3_d;
    logic [DATA_W-1:0] ex_rd1_q, ex_rd1_d;
    logic [DATA_W-1:0] ex_rd2_q, ex_rd2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;
    logic              hazard;
    logic              capture;

    hazard_detect u_hazard_detect (
        .valid_d    (valid_d),
        .valid_e    (ex_valid_q),
        .mem_read_e (ex_ctrl_q.mem_read),
        .a1_d       (a1_d),
        .a2_d       (a2_d),
        .a3_e       (ex_a3_q),
        .hazard     (hazard)
    );

    // Flush outranks stall in both states; anything not captured is a bubble.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flush_e) begin
                    capture = 1'b0;
                end else if (hazard) begin
                    stall_d = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = 3'(LOAD_STALL - 1);
                    end
                end else begin
                    capture = 1'b1;
                end
            end
            ST_STALL: begin
                if (flush_e) begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end else begin
                    stall_d = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        ex_valid_d = 1'b0;
        ex_a1_d    = '0;
        ex_a2_d    = '0;
        ex_a3_d    = '0;
        ex_rd1_d   = '0;
        ex_rd2_d   = '0;
        ex_imm_d   = '0;
        ex_ctrl_d  = '0;
        if (capture) begin
            ex_valid_d = valid_d;
            ex_a1_d    = a1_d;
            ex_a2_d    = a2_d;
            ex_a3_d    = a3_d;
            ex_rd1_d   = rd1_d;
            ex_rd2_d   = rd2_d;
            ex_imm_d   = imm_d;
            ex_ctrl_d  = '{reg_write: reg_write_d,
                           mem_read:  mem_read_d,
                           mem_write: mem_write_d,
                           alu_ctrl:  alu_op_e'(alu_ctrl_d)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= 3'd0;
            ex_valid_q <= 1'b0;
            ex_a1_q    <= '0;
            ex_a2_q    <= '0;
            ex_a3_q    <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_valid_q <= ex_valid_d;
            ex_a1_q    <= ex_a1_d;
            ex_a2_q    <= ex_a2_d;
            ex_a3_q    <= ex_a3_d;
            ex_rd1_q   <= ex_rd1_d;
            ex_rd2_q   <= ex_rd2_d;
            ex_imm_q   <= ex_imm_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign valid_e     = ex_valid_q;
    assign a1_e        = ex_a1_q;
    assign a2_e        = ex_a2_q;
    assign a3_e        = ex_a3_q;
    assign rd1_e       = ex_rd1_q;
    assign rd2_e       = ex_rd2_q;
    assign imm_e       = ex_imm_q;
    assign reg_write_e = ex_ctrl_q.reg_write;
    assign mem_read_e  = ex_ctrl_q.mem_read;
    assign mem_write_e = ex_ctrl_q.mem_write;
    assign alu_ctrl_e  = ex_ctrl_q.alu_ctrl;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: two instances (LOAD_STALL 1 and 3) share inputs
// and are checked against a slot-level reference model of the stage.
module tb_id_ex_stage_reg;
    import cpu_pkg::*;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic [ADDR_W-1:0] a3;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic              rw;
        logic              mr;
        logic              mw;
        logic [ALU_W-1:0]  alu;
    } slot_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    logic  flush_e;
    slot_t in_d;

    logic              stall1, valid_e1, rw_e1, mr_e1, mw_e1;
    logic [ADDR_W-1:0] a1_e1, a2_e1, a3_e1;
    logic [DATA_W-1:0] rd1_e1, rd2_e1, imm_e1;
    logic [ALU_W-1:0]  alu_e1;
    logic              stall3, valid_e3, rw_e3, mr_e3, mw_e3;
    logic [ADDR_W-1:0] a1_e3, a2_e3, a3_e3;
    logic [DATA_W-1:0] rd1_e3, rd2_e3, imm_e3;
    logic [ALU_W-1:0]  alu_e3;
    slot_t obs1, obs3;

    slot_t m1, m3;
    int    left1, left3;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.LOAD_STALL(1)) dut1 (
        .clk(clk), .reset(reset), .valid_d(in_d.valid),
        .a1_d(in_d.a1), .a2_d(in_d.a2), .a3_d(in_d.a3),
        .rd1_d(in_d.rd1), .rd2_d(in_d.rd2), .imm_d(in_d.imm),
        .reg_write_d(in_d.rw), .mem_read_d(in_d.mr), .mem_write_d(in_d.mw),
        .alu_ctrl_d(in_d.alu), .flush_e(flush_e), .stall_d(stall1),
        .valid_e(valid_e1), .a1_e(a1_e1), .a2_e(a2_e1), .a3_e(a3_e1),
        .rd1_e(rd1_e1), .rd2_e(rd2_e1), .imm_e(imm_e1),
        .reg_write_e(rw_e1), .mem_read_e(mr_e1), .mem_write_e(mw_e1),
        .alu_ctrl_e(alu_e1)
    );

    id_ex_stage_reg #(.LOAD_STALL(3)) dut3 (
        .clk(clk), .reset(reset), .valid_d(in_d.valid),
        .a1_d(in_d.a1), .a2_d(in_d.a2), .a3_d(in_d.a3),
        .rd1_d(in_d.rd1), .rd2_d(in_d.rd2), .imm_d(in_d.imm),
        .reg_write_d(in_d.rw), .mem_read_d(in_d.mr), .mem_write_d(in_d.mw),
        .alu_ctrl_d(in_d.alu), .flush_e(flush_e), .stall_d(stall3),
        .valid_e(valid_e3), .a1_e(a1_e3), .a2_e(a2_e3), .a3_e(a3_e3),
        .rd1_e(rd1_e3), .rd2_e(rd2_e3), .imm_e(imm_e3),
        .reg_write_e(rw_e3), .mem_read_e(mr_e3), .mem_write_e(mw_e3),
        .alu_ctrl_e(alu_e3)
    );

    assign obs1 = {valid_e1, a1_e1, a2_e1, a3_e1, rd1_e1, rd2_e1, imm_e1,
                   rw_e1, mr_e1, mw_e1, alu_e1};
    assign obs3 = {valid_e3, a1_e3, a2_e3, a3_e3, rd1_e3, rd2_e3, imm_e3,
                   rw_e3, mr_e3, mw_e3, alu_e3};

    // Reference: "left" is how many more bubble cycles the stage still owes.
    function automatic logic ref_hazard(slot_t e, slot_t d);
        return d.valid && e.valid && e.mr && e.a3 != 0 && e.a3 != 5'd19
            && (e.a3 == d.a1 || e.a3 == d.a2);
    endfunction

    function automatic logic ref_stall(slot_t e, int left, slot_t d, logic fl);
        if (fl) return 1'b0;
        if (left > 0) return 1'b1;
        return ref_hazard(e, d);
    endfunction

    task automatic ref_step(input int ls, inout slot_t e, inout int left);
        if (flush_e) begin
            e = '0;
            left = 0;
        end else if (left > 0) begin
            e = '0;
            left = left - 1;
        end else if (ref_hazard(e, in_d)) begin
            e = '0;
            left = ls - 1;
        end else begin
            e = in_d;
        end
    endtask

    task automatic clear_model();
        m1 = '0; m3 = '0; left1 = 0; left3 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            clear_model();
        end else begin
            ref_step(1, m1, left1);
            ref_step(3, m3, left3);
        end
        #1;
    endtask

    task automatic idle(input int n);
        in_d = '0;
        flush_e = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drive_load(input logic [4:0] dst);
        in_d = '0;
        in_d.valid = 1'b1; in_d.a1 = 5'd1; in_d.a2 = 5'd2; in_d.a3 = dst;
        in_d.mr = 1'b1; in_d.rw = 1'b1; in_d.rd1 = 19'($urandom);
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd5;
            2: return 5'd19;
            default: return 5'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        in_d = '0; flush_e = 1'b0;
        in_d.valid = 1'b1; in_d.rd1 = 19'h1234;
        reset = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (obs1 !== '0) begin n_bad++; $display("[TB] FAIL reset_out_ls1: got %h want 0", obs1); end
        n_cmp++; if (obs3 !== '0) begin n_bad++; $display("[TB] FAIL reset_out_ls3: got %h want 0", obs3); end
        n_cmp++; if (stall1 !== 1'b0 || stall3 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_stall: got %b%b want 00", stall1, stall3); end
        reset = 1'b1;
        tick();
        n_cmp++; if (rd1_e1 !== 19'h1234 || valid_e1 !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_release_capture: got rd1=%h v=%b want 1234 v=1", rd1_e1, valid_e1); end
        n_cmp++; if (obs3 !== m3) begin n_bad++; $display("[TB] FAIL reset_release_ls3: got %h want %h", obs3, m3); end
    endtask

    task automatic test_load_use(input logic [4:0] dep_a2);
        int st1, st3, arr1, arr3;
        logic [DATA_W-1:0] rd2v, got1, got3;
        st1 = 0; st3 = 0; arr1 = 0; arr3 = 0; got1 = '0; got3 = '0;
        idle(8);
        drive_load(5'd5);
        tick();
        in_d = '0;
        in_d.valid = 1'b1; in_d.a1 = 5'd5; in_d.a2 = dep_a2; in_d.a3 = 5'd7;
        in_d.rd2 = 19'($urandom); in_d.alu = 4'd3; in_d.rw = 1'b1;
        rd2v = in_d.rd2;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (stall1 === 1'b1) st1++;
            if (stall3 === 1'b1) st3++;
            tick();
            if (arr1 == 0 && valid_e1 === 1'b1 && a1_e1 === 5'd5) begin arr1 = k + 1; got1 = rd2_e1; end
            if (arr3 == 0 && valid_e3 === 1'b1 && a1_e3 === 5'd5) begin arr3 = k + 1; got3 = rd2_e3; end
        end
        n_cmp++; if (st1 != 1) begin n_bad++; $display("[TB] FAIL load_use_stalls_ls1: got %0d want 1", st1); end
        n_cmp++; if (st3 != 3) begin n_bad++; $display("[TB] FAIL load_use_stalls_ls3: got %0d want 3", st3); end
        n_cmp++; if (arr1 != 2) begin n_bad++; $display("[TB] FAIL load_use_arrival_ls1: got %0d want 2", arr1); end
        n_cmp++; if (arr3 != 4) begin n_bad++; $display("[TB] FAIL load_use_arrival_ls3: got %0d want 4", arr3); end
        n_cmp++; if (got1 !== rd2v || got3 !== rd2v) begin n_bad++; $display("[TB] FAIL load_use_rd2: got %h/%h want %h", got1, got3, rd2v); end
    endtask

    task automatic test_no_false_hazard();
        logic [4:0] dst [3];
        logic       isld [3];
        dst[0] = 5'd0;  isld[0] = 1'b1;
        dst[1] = 5'd19; isld[1] = 1'b1;
        dst[2] = 5'd5;  isld[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            idle(4);
            drive_load(dst[c]);
            in_d.mr = isld[c];
            in_d.mw = !isld[c];
            in_d.rw = isld[c];
            tick();
            in_d = '0;
            in_d.valid = 1'b1; in_d.a1 = dst[c]; in_d.a2 = dst[c];
            #1;
            n_cmp++; if (stall1 !== 1'b0 || stall3 !== 1'b0) begin n_bad++; $display("[TB] FAIL no_false_hazard_%0d: got %b%b want 00", c, stall1, stall3); end
            n_cmp++; if (valid_e3 !== 1'b1 || a3_e3 !== dst[c]) begin n_bad++; $display("[TB] FAIL no_false_hazard_ex_%0d: got v=%b a3=%0d want v=1 a3=%0d", c, valid_e3, a3_e3, dst[c]); end
        end
    endtask

    task automatic test_flush_mid_stall();
        idle(8);
        drive_load(5'd5);
        tick();
        in_d = '0;
        in_d.valid = 1'b1; in_d.a1 = 5'd5;
        #1;
        n_cmp++; if (stall3 !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_first_stall: got %b want 1", stall3); end
        tick();
        flush_e = 1'b1;
        #1;
        n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_stall_drop: got %b want 0", stall3); end
        tick();
        n_cmp++; if (valid_e3 !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_bubble: got %b want 0", valid_e3); end
        flush_e = 1'b0;
        in_d = '0;
        in_d.valid = 1'b1; in_d.a1 = 5'd7; in_d.a2 = 5'd8; in_d.a3 = 5'd9;
        in_d.rd1 = 19'($urandom);
        #1;
        n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_run_stall: got %b want 0", stall3); end
        tick();
        n_cmp++; if (valid_e3 !== 1'b1 || a1_e3 !== 5'd7 || rd1_e3 !== in_d.rd1) begin n_bad++; $display("[TB] FAIL flush_next_capture: got v=%b a1=%0d rd1=%h want v=1 a1=7 rd1=%h", valid_e3, a1_e3, rd1_e3, in_d.rd1); end
        n_cmp++; if (obs3 !== m3) begin n_bad++; $display("[TB] FAIL flush_model: got %h want %h", obs3, m3); end
    endtask

    task automatic test_reset_mid_stall();
        idle(8);
        drive_load(5'd5);
        tick();
        in_d = '0;
        in_d.valid = 1'b1; in_d.a1 = 5'd5;
        tick();
        #2;
        reset = 1'b0;
        #1;
        clear_model();
        n_cmp++; if (obs3 !== '0 || obs1 !== '0) begin n_bad++; $display("[TB] FAIL reset_mid_out: got %h/%h want 0", obs1, obs3); end
        n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mid_stall: got %b want 0", stall3); end
        tick();
        reset = 1'b1;
        in_d = '0;
        in_d.valid = 1'b1; in_d.a1 = 5'd6; in_d.rd1 = 19'($urandom);
        #1;
        n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mid_release_stall: got %b want 0", stall3); end
        tick();
        n_cmp++; if (valid_e3 !== 1'b1 || obs3 !== m3) begin n_bad++; $display("[TB] FAIL reset_mid_capture: got %h want %h", obs3, m3); end
    endtask

    task automatic test_random();
        logic e1, e3;
        idle(8);
        for (int i = 0; i < 400; i++) begin
            in_d.valid = ($urandom_range(0, 7) != 0);
            in_d.a1    = pick_reg();
            in_d.a2    = pick_reg();
            in_d.a3    = pick_reg();
            in_d.rd1   = 19'($urandom);
            in_d.rd2   = 19'($urandom);
            in_d.imm   = 19'($urandom);
            in_d.mr    = 1'($urandom);
            in_d.mw    = !in_d.mr && 1'($urandom);
            in_d.rw    = 1'($urandom);
            in_d.alu   = 4'($urandom);
            flush_e    = ($urandom_range(0, 15) == 0);
            #1;
            e1 = ref_stall(m1, left1, in_d, flush_e);
            e3 = ref_stall(m3, left3, in_d, flush_e);
            n_cmp++; if (stall1 !== e1) begin n_bad++; $display("[TB] FAIL rand_stall_ls1 @%0d: got %b want %b", i, stall1, e1); end
            n_cmp++; if (stall3 !== e3) begin n_bad++; $display("[TB] FAIL rand_stall_ls3 @%0d: got %b want %b", i, stall3, e3); end
            tick();
            n_cmp++; if (obs1 !== m1) begin n_bad++; $display("[TB] FAIL rand_ex_ls1 @%0d: got %h want %h", i, obs1, m1); end
            n_cmp++; if (obs3 !== m3) begin n_bad++; $display("[TB] FAIL rand_ex_ls3 @%0d: got %h want %h", i, obs3, m3); end
        end
        flush_e = 1'b0;
    endtask

    initial begin
        flush_e = 1'b0;
        in_d = '0;
        clear_model();
        test_reset();
        test_load_use(5'd2);
        test_load_use(5'd5);
        test_no_false_hazard();
        test_flush_mid_stall();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register directly downstream of the register file. Each cycle it latches register file read data (rd1/rd2), decoded immediate, register numbers and control bits for the execute stage. It owns load-use hazard detection: it stalls decode and injects bubbles for LOAD_STALL cycles when the instruction in EX is a load whose destination feeds the instruction in decode. It also applies branch flushes from EX.

Parameters:
DATA_W, 19, datapath and register width
ADDR_W, 5, register-number width
ALU_W, 4, ALU control width
LOAD_STALL, 1, bubbles required after a load before a dependent instruction (legal range 1..7)
PC_REG, 19, index of the PC register, which is never written and never a hazard source

Ports:
clk  in  1  pipeline clock; register updates on posedge
reset  in  1  asynchronous, active-low reset
valid_d  in  1  decode slot holds a real instruction
a1_d, a2_d  in  ADDR_W  source register numbers (same values driven to the register file a1/a2)
a3_d  in  ADDR_W  destination register number
rd1_d, rd2_d  in  DATA_W  register file read data
imm_d  in  DATA_W  sign-extended immediate
reg_write_d, mem_read_d, mem_write_d  in  1  control bits
alu_ctrl_d  in  ALU_W  ALU operation
flush_e  in  1  branch taken in EX; squash the decode instruction
stall_d  out  1  hold fetch/decode registers this cycle
valid_e  out  1  EX slot holds a real instruction
a1_e, a2_e, a3_e  out  ADDR_W  latched register numbers (for the forwarding unit)
rd1_e, rd2_e, imm_e  out  DATA_W  latched operands
reg_write_e, mem_read_e, mem_write_e  out  1  latched control
alu_ctrl_e  out  ALU_W  latched ALU operation

Behaviour:
- Reset low (asynchronous): every *_e output clears to 0, FSM goes to RUN, counter clears to 0, stall_d = 0. This matches the register file, which returns 0 on reads while reset is low.
- Bubble: valid_e = 0 and every *_e output = 0.
- hazard (combinational) = valid_d && valid_e && mem_read_e && a3_e != 0 && a3_e != PC_REG && (a3_e == a1_d || a3_e == a2_d).
- FSM states: RUN and STALL. A 3-bit counter cnt counts remaining stall cycles.
- RUN, flush_e = 1: load a bubble; stall_d = 0; stay in RUN.
- RUN, hazard = 1: stall_d = 1; load a bubble.
  - If LOAD_STALL > 1, go to STALL with cnt = LOAD_STALL-1.
  - Otherwise stay in RUN.
- RUN, otherwise: capture all *_d into *_e, with valid_e = valid_d; stall_d = 0.
- STALL: stall_d = 1 and load a bubble on every cycle; cnt decrements each cycle.
  - When cnt == 1, this is the last stall cycle; go to RUN.
  - flush_e in STALL: load a bubble, stall_d = 0, go to RUN, cnt = 0. Flush has priority over stall.
- Latency:
  - Inputs appear on the *_e outputs one cycle after capture.
  - A dependent instruction reaches EX exactly LOAD_STALL+1 cycles after its load entered EX.
- stall_d is combinational from state and hazard. It is valid in the same cycle so fetch/decode can hold.
- Register 0 (hard zero) and PC_REG (unwritable) never raise a hazard.
- A store (mem_write_e) never raises a hazard.
- A load with a3 == a1 == a2 raises a single stall sequence, not two.
- Back-to-back loads: each load is evaluated independently when it reaches EX.
- Register-file write-through is not handled here. The register file writes on negedge, so same-cycle write/read already returns new data.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W, ADDR_W, ALU_W and PC_REG constants.
  - The alu_ctrl encoding enum.
  - A packed ctrl_t struct {reg_write, mem_read, mem_write, alu_ctrl} so control travels as one field.
- One natural sub-module: hazard_detect, the purely combinational hazard equation.
- The FSM, counter and pipeline flops stay in id_ex_stage_reg.

Test Plan:
- Reset: hold reset=0 with valid_d=1 and rd1_d=19'h1234 on inputs -> all *_e = 0 and stall_d = 0. Release reset; the next posedge gives rd1_e = 19'h1234 and valid_e = 1.
- Load-use, LOAD_STALL=1: load into a3=5 in EX, decode a1_d=5 -> stall_d=1 for exactly 1 cycle and one bubble (valid_e=0). The dependent instruction is in EX on the following cycle.
- Load-use, LOAD_STALL=3: same stimulus -> stall_d high for 3 consecutive cycles and 3 bubbles, then the dependent instruction is captured with its rd2_d value intact.
- No false hazard:
  - Load into a3=0, decode a1_d=0 -> stall_d=0.
  - Load into a3=19 -> stall_d=0.
  - Store to a3=5, decode a1_d=5 -> stall_d=0.
- Flush mid-stall (LOAD_STALL=3): assert flush_e on the 2nd stall cycle -> bubble, stall_d=0 in that cycle, FSM back in RUN; the next instruction is captured normally.
- Reset mid-stall: drop reset during STALL -> outputs clear immediately without a clock edge, stall_d=0, and RUN after release.
